// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//   Pipelined barrel shifter: one registered stage per shift-amount bit.
//   Stage k shifts by 2^k when amt bit k is set. Valid/ready on both sides;
//   backpressure ripples back stage by stage and empty stages are refilled.
//   Modes: 00 logical right, 01 rotate right, 10 logical left, 11 arith right.
//   Optional feature macro: BSHIFT_CARRY_EN adds out_carry (last bit shifted
//   out, or out_data MSB for rotate; 0 when the total shift is 0).
module barrel_shifter_pipe #(
  parameter  int WIDTH  = 8,
  localparam int AMT_W  = $clog2(WIDTH),
  localparam int STAGES = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef BSHIFT_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_ROR = 2'b01,
    MODE_LSL = 2'b10,
    MODE_ASR = 2'b11
  } mode_e;

  // One shift step by a fixed distance sh. ASR keeps the MSB, which is the
  // original sign at every stage, so the sign travels with the data itself.
  function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       m,
                                                  input int               sh);
    logic [2*WIDTH-1:0] dd;
    dd         = {d, d} >> sh;
    shift_data = d >> sh;
    case (mode_e'(m))
      MODE_LSR: shift_data = d >> sh;
      MODE_ROR: shift_data = dd[WIDTH-1:0];
      MODE_LSL: shift_data = d << sh;
      MODE_ASR: shift_data = $signed(d) >>> sh;
      default:  shift_data = d >> sh;
    endcase
  endfunction

`ifdef BSHIFT_CARRY_EN
  // Last bit pushed out by one step. For rotate right this bit is also the
  // new MSB, so it equals out_data[WIDTH-1] once all stages are applied.
  function automatic logic shift_carry(input logic [WIDTH-1:0] d,
                                       input logic [1:0]       m,
                                       input int               sh);
    if (mode_e'(m) == MODE_LSL) shift_carry = d[WIDTH-sh];
    else                        shift_carry = d[sh-1];
  endfunction
`endif

  // Stage state
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [AMT_W-1:0]  amt_q  [STAGES];
  logic [1:0]        mode_q [STAGES];
`ifdef BSHIFT_CARRY_EN
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] src_carry;
`endif

  // Per-stage handshake and load sources
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_valid;
  logic [WIDTH-1:0]  src_data [STAGES];
  logic [AMT_W-1:0]  src_amt  [STAGES];
  logic [1:0]        src_mode [STAGES];

  // Ready chain: walk from the output back to the input. A stage advances
  // when it is full and the stage after it can load this cycle.
  always_comb begin : ready_chain
    logic take;
    // NOTE: combinational blocks use blocking '=' so each line sees the value
    // computed just above it; every output gets a default first, so no latch.
    adv  = '0;
    load = '0;
    take = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]  = valid_q[k] & take;
      load[k] = ~valid_q[k] | adv[k];
      take    = load[k];
    end
  end

  // Load sources: stage 0 takes the input port, stage k the stage before it.
  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_amt[0]   = in_amt;
    src_mode[0]  = in_mode;
`ifdef BSHIFT_CARRY_EN
    src_carry[0] = 1'b0;
`endif
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_mode[k]  = mode_q[k-1];
`ifdef BSHIFT_CARRY_EN
      src_carry[k] = carry_q[k-1];
`endif
    end
  end

  // Stage registers: reset clears everything; a loading stage takes its source
  // (shifted by 2^k if amt bit k is set); a vacated stage only drops valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst) begin
        // NOTE: the data path is reset too, because out_data must read 0 right
        // after reset; sequential state always uses non-blocking '<='.
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        amt_q[k]   <= '0;
        mode_q[k]  <= '0;
`ifdef BSHIFT_CARRY_EN
        carry_q[k] <= 1'b0;
`endif
      end else if (load[k]) begin
        valid_q[k] <= src_valid[k];
        if (src_valid[k]) begin
          data_q[k] <= src_amt[k][k] ? shift_data(src_data[k], src_mode[k], 1 << k)
                                     : src_data[k];
          amt_q[k]  <= src_amt[k];
          mode_q[k] <= src_mode[k];
`ifdef BSHIFT_CARRY_EN
          carry_q[k] <= src_amt[k][k] ? shift_carry(src_data[k], src_mode[k], 1 << k)
                                      : src_carry[k];
`endif
        end
      end
    end
  end

  // Outputs come straight from the last stage.
  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign busy      = |valid_q;
`ifdef BSHIFT_CARRY_EN
  assign out_carry = carry_q[STAGES-1];
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe
//   Scoreboard bench for barrel_shifter_pipe (WIDTH=8, latency 3). The driver
//   pushes the expected result at accept time; a monitor pops and compares
//   whenever a result is delivered. Define BSHIFT_CARRY_EN to check out_carry.
`timescale 1ns/1ps
module tb_barrel_shifter_pipe;

  typedef struct packed {
    logic [7:0]  data;
    logic        carry;
    logic        chk_lat;
    int unsigned acc_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
`ifdef BSHIFT_CARRY_EN
  logic       out_carry;
`endif

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;
  bit          lat_chk  = 1'b0;
  bit          busy_chk = 1'b0;

  barrel_shifter_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef BSHIFT_CARRY_EN
    ,
    .out_carry (out_carry)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: bit-by-bit definition of each mode for a total shift s.
  function automatic logic [8:0] ref_shift(input logic [7:0] d, input int s, input logic [1:0] m);
    logic [7:0] r;
    logic       c;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case (m)
        2'b00:   r[i] = (i + s < 8) ? d[(i + s) % 8] : 1'b0;
        2'b01:   r[i] = d[(i + s) % 8];
        2'b10:   r[i] = (i >= s) ? d[(i - s + 8) % 8] : 1'b0;
        default: r[i] = (i + s < 8) ? d[(i + s) % 8] : d[7];
      endcase
    end
    if (s == 0)        c = 1'b0;
    else if (m == 2'b10) c = d[8 - s];
    else               c = d[s - 1];
    return {r, c};
  endfunction

  task automatic push_exp(input logic [7:0] ed, input logic ec);
    exp_t e;
    e.data    = ed;
    e.carry   = ec;
    e.chk_lat = lat_chk;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Present one beat, wait (bounded) for acceptance, record its expectation.
  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                      input logic [7:0] ed, input logic ec, input bit must_ready);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (must_ready) check("stream_in_ready_stalls", waited, 0);
    if (!in_ready) check("accept_timeout", in_ready, 1);
    else           push_exp(ed, ec);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                            input bit must_ready);
    logic [8:0] r;
    r = ref_shift(d, int'(a), m);
    send(d, a, m, r[8:1], r[0], must_ready);
  endtask

  // Wait (bounded) for every expected beat to come out and the pipe to empty.
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented result against the queue head; pop on
  // transfer; while stalled, the presented result must not change.
  initial begin
    exp_t       e;
    logic       stalled;
    logic [7:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, held);
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", out_valid, 0);
          end else begin
            e = exp_q[0];
            check("out_data", out_data, e.data);
`ifdef BSHIFT_CARRY_EN
            check("out_carry", out_carry, e.carry);
`endif
            if (e.chk_lat && !stalled) check("latency", cyc - e.acc_cyc, 3);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        stalled = out_valid && !out_ready;
        held    = out_data;
      end
    end
  end

  // busy must be high exactly while some accepted beat is not yet delivered.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (busy_chk) check("busy", busy, exp_q.size() != 0);
    end
  end

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [1:0] m;
    logic [7:0] ed;
    logic       ec;
  } vec_t;

  vec_t vecs[12] = '{
    // amt=3, each mode
    '{8'h96, 3'd3, 2'b00, 8'h12, 1'b1},
    '{8'h96, 3'd3, 2'b01, 8'hD2, 1'b1},
    '{8'h96, 3'd3, 2'b10, 8'hB0, 1'b0},
    '{8'h96, 3'd3, 2'b11, 8'hF2, 1'b1},
    // amt=0, each mode
    '{8'h96, 3'd0, 2'b00, 8'h96, 1'b0},
    '{8'h96, 3'd0, 2'b01, 8'h96, 1'b0},
    '{8'h96, 3'd0, 2'b10, 8'h96, 1'b0},
    '{8'h96, 3'd0, 2'b11, 8'h96, 1'b0},
    // amt=7
    '{8'h96, 3'd7, 2'b11, 8'hFF, 1'b0},
    '{8'h96, 3'd7, 2'b00, 8'h01, 1'b0},
    '{8'h01, 3'd7, 2'b10, 8'h80, 1'b0},
    '{8'h96, 3'd7, 2'b01, 8'h2D, 1'b0}
  };

  logic [7:0] bp_in  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] bp_exp [4] = '{8'h22, 8'h44, 8'h66, 8'h88};

  initial begin
    int acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 1. Reset mid-stream with three beats in flight.
    out_ready = 1'b0;
    send_model(8'hC3, 3'd1, 2'b00, 1'b1);
    send_model(8'h5A, 3'd2, 2'b01, 1'b1);
    send_model(8'h7E, 3'd5, 2'b11, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // 2./3. Mode and edge-amount vectors, one at a time, latency checked.
    lat_chk = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].a, vecs[i].m, vecs[i].ed, vecs[i].ec, 1'b0);
      drain();
    end
    lat_chk  = 1'b0;
    busy_chk = 1'b1;

    // 4. Streaming: 16 back-to-back beats, in_ready must never drop.
    for (int i = 0; i < 16; i++)
      send_model(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b1);
    drain();

    // 5. Backpressure: out_ready low for 5 cycles with in_valid held high.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = bp_in[acc];
      in_amt   = 3'd1;
      in_mode  = 2'b10;
      @(negedge clk);
      if (in_ready) begin
        push_exp(bp_exp[acc], 1'b0);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_accepted", acc, 3);
    @(negedge clk);
    check("bp_in_ready_full", in_ready, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    #1 check("bp_in_ready_release", in_ready, 1);
    push_exp(bp_exp[3], 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // 6. Bubbles: a beat every 3rd cycle while out_ready toggles.
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send_model(8'hA5 ^ 8'(i * 37), 3'(i % 8), 2'(i % 4), 1'b0);
          repeat (2) begin
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        repeat (45) begin
          @(posedge clk);
          #1 out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    busy_chk = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
